// File: rtl/mem_load_pipe.sv
// mem_load_pipe: load memory stage that issues cache reads, merges split pieces and registers the result
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   i_v .. i_EIP        translated uop from the TLB stage (valid, read flag, address, bytes-1, split flag, passthroughs)
//   i_flush             kill everything in flight
//   i_stall             downstream cannot consume o_v this cycle
//   o_stall             upstream must hold its uop
//   cache_req_v/addr/size, cache_ack/rdata   cache read request and response
//   o_v, o_data, o_pa, o_CS, o_EIP           registered result to execute
module mem_load_pipe #(
    parameter int PA_W = 15,
    parameter int CS_W = 51
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_v,
    input  logic            i_memRen,
    input  logic [PA_W-1:0] i_pa,
    input  logic [1:0]      i_reqSize,
    input  logic            i_spill,
    input  logic [CS_W-1:0] i_CS,
    input  logic [31:0]     i_EIP,
    input  logic            i_flush,
    input  logic            i_stall,
    output logic            o_stall,
    output logic            cache_req_v,
    output logic [PA_W-1:0] cache_addr,
    output logic [1:0]      cache_size,
    input  logic            cache_ack,
    input  logic [31:0]     cache_rdata,
    output logic            o_v,
    output logic [31:0]     o_data,
    output logic [PA_W-1:0] o_pa,
    output logic [CS_W-1:0] o_CS,
    output logic [31:0]     o_EIP
);
    typedef enum logic [1:0] {IDLE, ISSUE, SPLIT, HOLD} state_t;

    state_t          state_q, state_d;
    logic [PA_W-1:0] pa_q, pa_d, fpa_q, fpa_d, out_pa_q, out_pa_d;
    logic [1:0]      size_q, size_d;
    logic            spill_q, spill_d, out_v_q, out_v_d;
    logic [CS_W-1:0] cs_q, cs_d, out_cs_q, out_cs_d;
    logic [31:0]     eip_q, eip_d, out_eip_q, out_eip_d;
    logic [31:0]     acc_q, acc_d, out_data_q, out_data_d;
    logic [2:0]      n1_q, n1_d;
    logic            accept, out_free;
    logic [31:0]     piece, merged;

    assign o_stall     = state_q == ISSUE || state_q == HOLD || (out_v_q && i_stall && state_q != SPLIT);
    assign accept      = i_v && !o_stall;
    assign out_free    = !out_v_q || !i_stall;
    assign cache_req_v = state_q == ISSUE;
    assign cache_addr  = pa_q;
    assign cache_size  = size_q;
    assign o_v         = out_v_q;
    assign o_data      = out_data_q;
    assign o_pa        = out_pa_q;
    assign o_CS        = out_cs_q;
    assign o_EIP       = out_eip_q;

    // Keep only the size+1 requested bytes, then place them after the n1 bytes already gathered;
    // anything shifted beyond bit 31 falls off.
    assign piece  = cache_rdata & (32'hFFFF_FFFF >> {~size_q, 3'b000});
    assign merged = acc_q | (piece << {n1_q, 3'b000});

    always_comb begin
        state_d    = state_q;
        pa_d       = pa_q;
        fpa_d      = fpa_q;
        size_d     = size_q;
        spill_d    = spill_q;
        cs_d       = cs_q;
        eip_d      = eip_q;
        acc_d      = acc_q;
        n1_d       = n1_q;
        out_v_d    = out_v_q && i_stall;
        out_data_d = out_data_q;
        out_pa_d   = out_pa_q;
        out_cs_d   = out_cs_q;
        out_eip_d  = out_eip_q;
        if (i_flush) begin
            state_d = IDLE;
            acc_d   = '0;
            n1_d    = '0;
            out_v_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    if (i_memRen) begin
                        pa_d    = i_pa;
                        fpa_d   = i_pa;
                        size_d  = i_reqSize;
                        spill_d = i_spill;
                        cs_d    = i_CS;
                        eip_d   = i_EIP;
                        acc_d   = '0;
                        n1_d    = '0;
                        state_d = ISSUE;
                    end else begin
                        out_v_d    = 1'b1;
                        out_data_d = '0;
                        out_pa_d   = i_pa;
                        out_cs_d   = i_CS;
                        out_eip_d  = i_EIP;
                    end
                end
                ISSUE: if (cache_ack) begin
                    acc_d = merged;
                    if (spill_q) begin
                        n1_d    = {1'b0, size_q} + 3'd1;
                        state_d = SPLIT;
                    end else if (out_free) begin
                        out_v_d    = 1'b1;
                        out_data_d = merged;
                        out_pa_d   = fpa_q;
                        out_cs_d   = cs_q;
                        out_eip_d  = eip_q;
                        acc_d      = '0;
                        n1_d       = '0;
                        state_d    = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
                // Second piece: only its address and size matter; it is always a read.
                SPLIT: if (accept) begin
                    pa_d    = i_pa;
                    size_d  = i_reqSize;
                    spill_d = 1'b0;
                    state_d = ISSUE;
                end
                HOLD: if (out_free) begin
                    out_v_d    = 1'b1;
                    out_data_d = acc_q;
                    out_pa_d   = fpa_q;
                    out_cs_d   = cs_q;
                    out_eip_d  = eip_q;
                    acc_d      = '0;
                    n1_d       = '0;
                    state_d    = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            pa_q       <= '0;
            fpa_q      <= '0;
            size_q     <= '0;
            spill_q    <= 1'b0;
            cs_q       <= '0;
            eip_q      <= '0;
            acc_q      <= '0;
            n1_q       <= '0;
            out_v_q    <= 1'b0;
            out_data_q <= '0;
            out_pa_q   <= '0;
            out_cs_q   <= '0;
            out_eip_q  <= '0;
        end else begin
            state_q    <= state_d;
            pa_q       <= pa_d;
            fpa_q      <= fpa_d;
            size_q     <= size_d;
            spill_q    <= spill_d;
            cs_q       <= cs_d;
            eip_q      <= eip_d;
            acc_q      <= acc_d;
            n1_q       <= n1_d;
            out_v_q    <= out_v_d;
            out_data_q <= out_data_d;
            out_pa_q   <= out_pa_d;
            out_cs_q   <= out_cs_d;
            out_eip_q  <= out_eip_d;
        end
    end
endmodule

// File: doc/mem_load_pipe.md
Name: mem_load_pipe

Overview:
- Memory stage directly downstream of the TLB/address stage.
- Accepts one translated uop per cycle and issues cache read requests for memory-reading uops.
- Reassembles page/line-split accesses, which arrive as two consecutive pieces, into a single 32-bit result.
- Presents a registered result to the execute stage with a valid/stall handshake. Non-memory uops pass through with 1-cycle latency.

Parameters:
- PA_W, 15, physical address width.
- CS_W, 51, control-store word width (passed through).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- i_v  input  1  upstream uop valid
- i_memRen  input  1  uop reads memory
- i_pa  input  PA_W  physical byte address of this piece
- i_reqSize  input  2  bytes-1 of this piece (0..3)
- i_spill  input  1  this piece is the first half of a split access
- i_CS  input  CS_W  control word (passthrough)
- i_EIP  input  32  uop EIP (passthrough)
- i_flush  input  1  global invalidate; kill everything in flight
- i_stall  input  1  downstream cannot consume o_v this cycle
- o_stall  output  1  stall to TLB stage (upstream holds its uop)
- cache_req_v  output  1  cache read request valid
- cache_addr  output  PA_W  request address
- cache_size  output  2  request bytes-1
- cache_ack  input  1  read data valid this cycle
- cache_rdata  input  32  byte at cache_addr in [7:0], ascending
- o_v  output  1  result valid
- o_data  output  32  assembled load data, zero-extended
- o_pa  output  PA_W  address of first piece
- o_CS  output  CS_W  control word of first piece
- o_EIP  output  32  EIP of first piece

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE; o_v, o_data, o_pa, o_CS, o_EIP, cache_req_v, accumulator, byte count all 0; o_stall=0 the following cycle. Reset overrides flush and all other inputs.
- Accept: an upstream uop is accepted at an edge where i_v=1 and o_stall=0.
- Output register: out_v is consumed at any edge where o_v=1 and i_stall=0. It may load new data at the same edge it is consumed (full throughput). It is free when o_v=0 or is being consumed.
- o_stall = (state==ISSUE) | (state==HOLD) | (o_v & i_stall & state!=SPLIT).
- FSM states: IDLE, ISSUE, SPLIT, HOLD.
- IDLE, accept with i_memRen=0: load the output register next edge (o_data=0, passthrough fields). o_v rises 1 cycle after accept. State stays IDLE.
- IDLE, accept with i_memRen=1:
  - Latch pa/size/CS/EIP/spill; go ISSUE.
  - cache_req_v=1 from the cycle after accept until and including the cycle of cache_ack.
  - cache_addr and cache_size are stable while requesting.
- ISSUE on cache_ack, spill=1:
  - acc[7:0..] = rdata bytes 0..size; n1=size+1; go SPLIT.
  - cache_req_v falls next cycle.
- ISSUE on cache_ack, final piece:
  - merged = acc | (rdata masked to size+1 bytes) << 8*n1.
  - n1=0 for an unsplit access.
  - Bytes beyond n1+size+1 are zeroed; bytes shifted past bit 31 are dropped.
  - If the output register is free, load it and go IDLE; else go HOLD.
- SPLIT:
  - The next accepted valid uop is the second piece; its i_spill and i_memRen are ignored, and it is treated as a read.
  - Latch its pa/size only; o_pa/o_CS/o_EIP keep the first-piece values. Go ISSUE.
- HOLD: when the output register frees, load the merged data and go IDLE.
- Flush (i_flush=1 at an edge, rst=1):
  - State goes to IDLE; accumulator, n1 and out_v are cleared.
  - cache_req_v=0 next cycle.
  - A cache_ack in the same cycle is discarded.
  - An upstream uop presented the same cycle is not accepted.
- cache_ack outside ISSUE is ignored.

Test Plan:
- Aligned load: accept pa=0x0104 size=3; ack 2 cycles later with rdata=0xDEADBEEF -> cache_req_v high 2 cycles at addr 0x0104 size 3; o_stall high those cycles; o_v one cycle later with o_data=0xDEADBEEF, o_pa=0x0104.
- 2+2 split: pa=0x0FFE size=1 spill=1, rdata=0xFFFF3412; then pa=0x1000 size=1, rdata=0xFFFF7856 -> single o_v with o_data=0x78563412, o_pa=0x0FFE, first-piece EIP.
- 1+3 split and byte load: size0 rdata=0x000000AA, then size2 rdata=0x11CCBBDD -> o_data=0xCCBBDDAA; lone size0 load of rdata=0x12345678 -> o_data=0x00000078.
- Backpressure: three non-mem uops back-to-back with i_stall=1 for 2 cycles after the first o_v -> o_v held with unchanged data, o_stall high, no uop lost or duplicated, order preserved; load ack arriving while stalled goes HOLD then outputs.
- Flush: i_flush in the same cycle as cache_ack of a load -> no o_v, cache_req_v=0 next cycle, state IDLE; a following load completes normally; flush in SPLIT drops the first piece.
- Reset mid-operation: rst=0 during SPLIT with o_v=1 -> next cycle all outputs 0, o_stall=0; a subsequent aligned load behaves as in the first scenario.
